// File: rtl/cordic_tab_loader.sv
// CORDIC table loader: packs 16-bit words into 48-bit table entries and writes them out.
// Optional checksum word after the last entry is enabled by `define CORDIC_TAB_LOADER_CHKSUM_EN.
module cordic_tab_loader #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        wen,
    output logic [5:0]  index_wri,
    output logic [47:0] D,
    output logic        cen,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [5:0] LAST_ENTRY = 6'(ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
`ifdef CORDIC_TAB_LOADER_CHKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  entry_cnt;
    logic [1:0]  word_cnt;
    logic [15:0] word0, word1;
    logic        start_load;
    logic        accept_data;

    assign start_load  = start && (state == IDLE || state == DONE);
    assign accept_data = (state == COLLECT) && din_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = COLLECT;
            COLLECT:    if (din_valid && word_cnt == 2'd2) state_nxt = WRITE;
            WRITE: begin
                if (entry_cnt == LAST_ENTRY) begin
`ifdef CORDIC_TAB_LOADER_CHKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = COLLECT;
                end
            end
`ifdef CORDIC_TAB_LOADER_CHKSUM_EN
            CHK:        if (din_valid) state_nxt = DONE;
`endif
            default:    state_nxt = IDLE;
        endcase
    end

    // Words 0 and 1 are staged so D only changes on the edge that launches a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_cnt <= '0;
            word_cnt  <= '0;
            word0     <= '0;
            word1     <= '0;
            D         <= '0;
            index_wri <= '0;
        end else begin
            if (start_load) begin
                entry_cnt <= '0;
                word_cnt  <= '0;
            end
            if (accept_data) begin
                case (word_cnt)
                    2'd0:    word0 <= din;
                    2'd1:    word1 <= din;
                    default: begin
                        D         <= {word0, word1, din};
                        index_wri <= entry_cnt;
                    end
                endcase
                word_cnt <= (word_cnt == 2'd2) ? 2'd0 : word_cnt + 2'd1;
            end
            if (state == WRITE) begin
                entry_cnt <= entry_cnt + 6'd1;
            end
        end
    end

`ifdef CORDIC_TAB_LOADER_CHKSUM_EN
    logic [15:0] chk_acc;
    logic        err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_acc <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start_load) begin
                chk_acc <= '0;
                err_q   <= 1'b0;
            end
            if (accept_data) begin
                chk_acc <= chk_acc ^ din;
            end
            if (state == CHK && din_valid) begin
                err_q <= (din != chk_acc);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        wen       = 1'b0;
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cen       = 1'b0;
        case (state)
            COLLECT: begin
                din_ready = 1'b1;
                busy      = 1'b1;
            end
            WRITE: begin
                wen  = 1'b1;
                busy = 1'b1;
            end
`ifdef CORDIC_TAB_LOADER_CHKSUM_EN
            CHK: begin
                din_ready = 1'b1;
                busy      = 1'b1;
            end
`endif
            DONE: begin
                done = 1'b1;
                cen  = !err;
            end
            default: ;
        endcase
    end

endmodule
